// File: rtl/alien_formation.sv
// Alien formation controller: alive mask, marching origin, pixel hit lookup, kill handling.
// Latency: pixel lookup and kill ack are registered (1 cycle); a step is visible 1 cycle after its frame_tick.
// Backpressure: none; hit requests to dead or out-of-range targets are dropped with hit_ack low.
module alien_formation #(
  parameter int ROWS      = 5,
  parameter int COLS      = 11,
  parameter int CELL_W    = 32,
  parameter int CELL_H    = 32,
  parameter int SPR_W     = 24,
  parameter int SPR_H     = 16,
  parameter int START_X   = 64,
  parameter int START_Y   = 48,
  parameter int STEP_X    = 4,
  parameter int STEP_Y    = 16,
  parameter int X_MIN     = 8,
  parameter int X_MAX     = 631,
  parameter int FLOOR_Y   = 400,
  parameter int SPEED_DIV = 4,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int NW = $clog2(ROWS*COLS+1)
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          frame_tick,
  input  logic          restart,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          hit_valid,
  input  logic [RW-1:0] hit_row,
  input  logic [CW-1:0] hit_col,
  output logic          hit_ack,
  output logic          is_alien,
  output logic [RW-1:0] pix_row,
  output logic [CW-1:0] pix_col,
  output logic [9:0]    origin_x,
  output logic [9:0]    origin_y,
  output logic [NW-1:0] alive_count,
  output logic          step_pulse,
  output logic          wave_clear,
  output logic          landed
);

  localparam int CXS = $clog2(CELL_W);
  localparam int CYS = $clog2(CELL_H);

  typedef enum logic [2:0] {MARCH_R, MARCH_L, DESC_TO_L, DESC_TO_R, CLEAR, LANDED} state_t;

  state_t                     r_state, w_state_nxt;
  logic [ROWS-1:0][COLS-1:0]  r_mask;
  logic [9:0]                 r_ox, r_oy, w_ox_nxt, w_oy_nxt;
  logic [NW-1:0]              r_alive;
  logic [NW:0]                r_timer;
  logic                       r_step_pulse, r_hit_ack, r_wave_clear, r_landed;
  logic                       r_is_alien;
  logic [RW-1:0]              r_pix_row;
  logic [CW-1:0]              r_pix_col;

  logic [COLS-1:0]            w_colany;
  logic [ROWS-1:0]            w_rowany;
  logic [CW-1:0]              w_lc, w_rc;
  logic [RW-1:0]              w_br;
  int                         w_right, w_left, w_bottom, w_period;
  logic                       w_fire, w_step, w_active, w_hit_ok;
  logic [10:0]                w_dx, w_dy;
  logic [9-CXS:0]             w_pcol;
  logic [9-CYS:0]             w_prow;
  logic                       w_pix_hit;

  // Occupied columns/rows of the live mask and the extreme indices used for edge decisions
  always_comb begin
    w_colany = '0;
    w_rowany = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r_mask[r][c]) begin
          w_colany[c] = 1'b1;
          w_rowany[r] = 1'b1;
        end
      end
    end
    w_lc = '0;
    w_rc = '0;
    w_br = '0;
    for (int c = COLS-1; c >= 0; c--) if (w_colany[c]) w_lc = CW'(c);
    for (int c = 0; c < COLS; c++)    if (w_colany[c]) w_rc = CW'(c);
    for (int r = 0; r < ROWS; r++)    if (w_rowany[r]) w_br = RW'(r);
  end

  assign w_right  = int'(r_ox) + int'(w_rc) * CELL_W + SPR_W - 1;
  assign w_left   = int'(r_ox) + int'(w_lc) * CELL_W;
  assign w_bottom = int'(r_oy) + int'(w_br) * CELL_H + SPR_H - 1;
  assign w_period = 1 + int'(r_alive) / SPEED_DIV;
  assign w_fire   = frame_tick && ((int'(r_timer) + 1) >= w_period);
  assign w_active = (r_state == MARCH_R) || (r_state == MARCH_L) ||
                    (r_state == DESC_TO_L) || (r_state == DESC_TO_R);
  assign w_hit_ok = hit_valid && (int'(hit_row) < ROWS) && (int'(hit_col) < COLS) &&
                    r_mask[hit_row][hit_col];

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= MARCH_R;
    else          r_state <= w_state_nxt;
  end

  // Next state and next origin; a dead formation wins over a landed one
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_ox_nxt    = r_ox;
    w_oy_nxt    = r_oy;
    if (restart) begin
      w_state_nxt = MARCH_R;
    end else if (r_state != CLEAR && r_alive == '0) begin
      w_state_nxt = CLEAR;
    end else if (w_active && w_bottom >= FLOOR_Y) begin
      w_state_nxt = LANDED;
    end else if (w_active && w_fire) begin
      w_step = 1'b1;
      case (r_state)
        MARCH_R: begin
          if (w_right + STEP_X > X_MAX) begin
            w_oy_nxt    = r_oy + 10'(STEP_Y);
            w_state_nxt = DESC_TO_L;
          end else begin
            w_ox_nxt = r_ox + 10'(STEP_X);
          end
        end
        MARCH_L: begin
          if (w_left - STEP_X < X_MIN) begin
            w_oy_nxt    = r_oy + 10'(STEP_Y);
            w_state_nxt = DESC_TO_R;
          end else begin
            w_ox_nxt = r_ox - 10'(STEP_X);
          end
        end
        DESC_TO_L: begin
          w_ox_nxt    = r_ox - 10'(STEP_X);
          w_state_nxt = MARCH_L;
        end
        DESC_TO_R: begin
          w_ox_nxt    = r_ox + 10'(STEP_X);
          w_state_nxt = MARCH_R;
        end
        default: w_step = 1'b0;
      endcase
    end
  end

  // Formation datapath: origin, mask, alive count, step timer, sticky flags
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_mask       <= '1;
      r_ox         <= 10'(START_X);
      r_oy         <= 10'(START_Y);
      r_alive      <= NW'(ROWS*COLS);
      r_timer      <= '0;
      r_step_pulse <= 1'b0;
      r_hit_ack    <= 1'b0;
      r_wave_clear <= 1'b0;
      r_landed     <= 1'b0;
    end else begin
      r_step_pulse <= w_step;
      r_hit_ack    <= 1'b0;
      if (restart) begin
        r_mask       <= '1;
        r_ox         <= 10'(START_X);
        r_oy         <= 10'(START_Y);
        r_alive      <= NW'(ROWS*COLS);
        r_timer      <= '0;
        r_wave_clear <= 1'b0;
        r_landed     <= 1'b0;
      end else begin
        r_ox <= w_ox_nxt;
        r_oy <= w_oy_nxt;
        if (!w_active || w_step)  r_timer <= '0;
        else if (frame_tick)      r_timer <= r_timer + (NW+1)'(1);
        if (w_hit_ok) begin
          r_mask[hit_row][hit_col] <= 1'b0;
          r_alive                  <= r_alive - NW'(1);
          r_hit_ack                <= 1'b1;
        end
        if (w_state_nxt == CLEAR)  r_wave_clear <= 1'b1;
        if (w_state_nxt == LANDED) r_landed     <= 1'b1;
      end
    end
  end

  assign w_dx   = {1'b0, DrawX} - {1'b0, r_ox};
  assign w_dy   = {1'b0, DrawY} - {1'b0, r_oy};
  assign w_pcol = w_dx[9:CXS];
  assign w_prow = w_dy[9:CYS];
  assign w_pix_hit = !w_dx[10] && !w_dy[10] &&
                     (int'(w_pcol) < COLS) && (int'(w_prow) < ROWS) &&
                     (int'(w_dx[CXS-1:0]) < SPR_W) && (int'(w_dy[CYS-1:0]) < SPR_H) &&
                     r_mask[w_prow[RW-1:0]][w_pcol[CW-1:0]];

  // Registered pixel lookup; indices forced to zero off-sprite
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_is_alien <= 1'b0;
      r_pix_row  <= '0;
      r_pix_col  <= '0;
    end else begin
      r_is_alien <= w_pix_hit;
      r_pix_row  <= w_pix_hit ? w_prow[RW-1:0] : '0;
      r_pix_col  <= w_pix_hit ? w_pcol[CW-1:0] : '0;
    end
  end

  assign hit_ack     = r_hit_ack;
  assign is_alien    = r_is_alien;
  assign pix_row     = r_pix_row;
  assign pix_col     = r_pix_col;
  assign origin_x    = r_ox;
  assign origin_y    = r_oy;
  assign alive_count = r_alive;
  assign step_pulse  = r_step_pulse;
  assign wave_clear  = r_wave_clear;
  assign landed      = r_landed;

endmodule

// File: tb/tb_alien_formation.sv
// Directed bench for alien_formation with default parameters.
// Latency: outputs are sampled 1 time unit after the rising edge that produced them.
// Backpressure: not applicable; stimulus is driven one request per cycle.
module tb_alien_formation;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       frame_tick = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic       hit_valid = 1'b0;
  logic [2:0] hit_row = '0;
  logic [3:0] hit_col = '0;
  logic       hit_ack, is_alien, step_pulse, wave_clear, landed;
  logic [2:0] pix_row;
  logic [3:0] pix_col;
  logic [9:0] origin_x, origin_y;
  logic [5:0] alive_count;

  int tests = 0;
  int fails = 0;

  alien_formation dut (
    .CLK(CLK), .RESET_N(RESET_N), .frame_tick(frame_tick), .restart(restart),
    .DrawX(DrawX), .DrawY(DrawY), .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
    .hit_ack(hit_ack), .is_alien(is_alien), .pix_row(pix_row), .pix_col(pix_col),
    .origin_x(origin_x), .origin_y(origin_y), .alive_count(alive_count),
    .step_pulse(step_pulse), .wave_clear(wave_clear), .landed(landed)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick_once();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  // Issue frame ticks until a step appears; returns the tick count
  task automatic do_step(output int n);
    bit got;
    got = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick_once();
      n++;
      if (step_pulse) got = 1'b1;
    end
    cyc();
    if (!got) begin
      tests++; fails++;
      $display("FAIL step_timeout: no step_pulse within %0d ticks", n);
    end
  endtask

  task automatic hit(input logic [2:0] r, input logic [3:0] c);
    hit_valid = 1'b1; hit_row = r; hit_col = c;
    cyc();
    hit_valid = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    cyc(); cyc();
    RESET_N = 1'b1;
    cyc();
    tests++; if (origin_x !== 10'd64) begin fails++; $display("FAIL reset_ox: got %0d want 64", origin_x); end
    tests++; if (origin_y !== 10'd48) begin fails++; $display("FAIL reset_oy: got %0d want 48", origin_y); end
    tests++; if (alive_count !== 6'd55) begin fails++; $display("FAIL reset_alive: got %0d want 55", alive_count); end
    tests++; if ({step_pulse, hit_ack, wave_clear, landed, is_alien} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 00000", {step_pulse, hit_ack, wave_clear, landed, is_alien});
    end
    tests++; if ({pix_row, pix_col} !== 7'd0) begin fails++; $display("FAIL reset_pix: got %0d/%0d want 0/0", pix_row, pix_col); end
  endtask

  task automatic test_pixel();
    logic [9:0] xs [7] = '{10'd64, 10'd87, 10'd88, 10'd384, 10'd416, 10'd64, 10'd64};
    logic [9:0] ys [7] = '{10'd48, 10'd48, 10'd48, 10'd176, 10'd176, 10'd64, 10'd80};
    logic       ea [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0] er [7] = '{3'd0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd1};
    logic [3:0] ec [7] = '{4'd0, 4'd0, 4'd0, 4'd10, 4'd0, 4'd0, 4'd0};
    for (int i = 0; i < 7; i++) begin
      DrawX = xs[i]; DrawY = ys[i];
      cyc();
      tests++; if (is_alien !== ea[i]) begin fails++; $display("FAIL pix_alien[%0d]: got %b want %b", i, is_alien, ea[i]); end
      tests++; if (pix_row !== er[i]) begin fails++; $display("FAIL pix_row[%0d]: got %0d want %0d", i, pix_row, er[i]); end
      tests++; if (pix_col !== ec[i]) begin fails++; $display("FAIL pix_col[%0d]: got %0d want %0d", i, pix_col, ec[i]); end
    end
    DrawX = '0; DrawY = '0;
  endtask

  task automatic test_first_step();
    int n;
    do_step(n);
    tests++; if (n !== 14) begin fails++; $display("FAIL first_period: got %0d ticks want 14", n); end
    tests++; if (step_pulse !== 1'b0) begin fails++; $display("FAIL step_one_cycle: got %b want 0", step_pulse); end
    tests++; if (origin_x !== 10'd68 || origin_y !== 10'd48) begin
      fails++; $display("FAIL first_move: got (%0d,%0d) want (68,48)", origin_x, origin_y);
    end
  endtask

  task automatic test_march_right();
    int n;
    for (int i = 0; i < 55; i++) do_step(n);
    tests++; if (origin_x !== 10'd288 || origin_y !== 10'd48) begin
      fails++; $display("FAIL right_limit: got (%0d,%0d) want (288,48)", origin_x, origin_y);
    end
    do_step(n);
    tests++; if (origin_x !== 10'd288 || origin_y !== 10'd64) begin
      fails++; $display("FAIL descend: got (%0d,%0d) want (288,64)", origin_x, origin_y);
    end
    do_step(n);
    tests++; if (origin_x !== 10'd284 || origin_y !== 10'd64) begin
      fails++; $display("FAIL desc_to_l: got (%0d,%0d) want (284,64)", origin_x, origin_y);
    end
    do_step(n);
    tests++; if (origin_x !== 10'd280 || n !== 14) begin
      fails++; $display("FAIL march_l: got x=%0d ticks=%0d want x=280 ticks=14", origin_x, n);
    end
  endtask

  task automatic test_async_reset();
    #2;
    RESET_N = 1'b0;
    #1;
    tests++; if (origin_x !== 10'd64 || origin_y !== 10'd48 || alive_count !== 6'd55) begin
      fails++; $display("FAIL async_reset: got (%0d,%0d) alive %0d want (64,48) alive 55", origin_x, origin_y, alive_count);
    end
    #3;
    RESET_N = 1'b1;
    cyc();
  endtask

  task automatic test_dead_hit();
    hit(3'd2, 4'd3);
    tests++; if (hit_ack !== 1'b1 || alive_count !== 6'd54) begin
      fails++; $display("FAIL live_hit: got ack %b alive %0d want 1/54", hit_ack, alive_count);
    end
    hit(3'd2, 4'd3);
    tests++; if (hit_ack !== 1'b0 || alive_count !== 6'd54) begin
      fails++; $display("FAIL dead_hit: got ack %b alive %0d want 0/54", hit_ack, alive_count);
    end
    hit(3'd5, 4'd0);
    tests++; if (hit_ack !== 1'b0 || alive_count !== 6'd54) begin
      fails++; $display("FAIL row_range: got ack %b alive %0d want 0/54", hit_ack, alive_count);
    end
    hit(3'd0, 4'd11);
    tests++; if (hit_ack !== 1'b0 || alive_count !== 6'd54) begin
      fails++; $display("FAIL col_range: got ack %b alive %0d want 0/54", hit_ack, alive_count);
    end
  endtask

  task automatic test_same_cycle();
    int n;
    int pulses;
    do_restart();
    tests++; if (alive_count !== 6'd55 || origin_x !== 10'd64) begin
      fails++; $display("FAIL restart_a: got alive %0d x %0d want 55/64", alive_count, origin_x);
    end
    for (int r = 0; r < 4; r++) begin
      hit(3'(r), 4'd10);
      tests++; if (hit_ack !== 1'b1) begin fails++; $display("FAIL sc_kill[%0d]: got ack %b want 1", r, hit_ack); end
    end
    for (int i = 0; i < 56; i++) do_step(n);
    tests++; if (origin_x !== 10'd288 || n !== 13) begin
      fails++; $display("FAIL sc_edge: got x=%0d ticks=%0d want x=288 ticks=13", origin_x, n);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick_once();
      if (step_pulse) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL sc_early: got %0d steps want 0", pulses); end
    frame_tick = 1'b1; hit_valid = 1'b1; hit_row = 3'd4; hit_col = 4'd10;
    cyc();
    frame_tick = 1'b0; hit_valid = 1'b0;
    tests++; if (step_pulse !== 1'b1 || origin_x !== 10'd288 || origin_y !== 10'd64) begin
      fails++; $display("FAIL sc_step: got pulse %b (%0d,%0d) want 1 (288,64)", step_pulse, origin_x, origin_y);
    end
    tests++; if (hit_ack !== 1'b1 || alive_count !== 6'd50) begin
      fails++; $display("FAIL sc_hit: got ack %b alive %0d want 1/50", hit_ack, alive_count);
    end
  endtask

  task automatic test_kill_column();
    int n;
    do_restart();
    for (int r = 0; r < 5; r++) begin
      hit(3'(r), 4'd10);
      tests++; if (hit_ack !== 1'b1 || alive_count !== 6'(54 - r)) begin
        fails++; $display("FAIL col_kill[%0d]: got ack %b alive %0d want 1/%0d", r, hit_ack, alive_count, 54 - r);
      end
    end
    do_step(n);
    tests++; if (n !== 13 || origin_x !== 10'd68) begin
      fails++; $display("FAIL col_period: got ticks=%0d x=%0d want 13/68", n, origin_x);
    end
    for (int i = 0; i < 63; i++) do_step(n);
    tests++; if (origin_x !== 10'd320 || origin_y !== 10'd48) begin
      fails++; $display("FAIL col_edge: got (%0d,%0d) want (320,48)", origin_x, origin_y);
    end
    do_step(n);
    tests++; if (origin_x !== 10'd320 || origin_y !== 10'd64) begin
      fails++; $display("FAIL col_descend: got (%0d,%0d) want (320,64)", origin_x, origin_y);
    end
    do_step(n);
    tests++; if (origin_x !== 10'd316) begin fails++; $display("FAIL col_turn: got x=%0d want 316", origin_x); end
  endtask

  task automatic test_wave_clear();
    int acks;
    int pulses;
    do_restart();
    tests++; if (origin_x !== 10'd64 || origin_y !== 10'd48 || alive_count !== 6'd55) begin
      fails++; $display("FAIL restart_b: got (%0d,%0d) alive %0d want (64,48) 55", origin_x, origin_y, alive_count);
    end
    acks = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 11; c++) begin
        hit(3'(r), 4'(c));
        if (hit_ack) acks++;
      end
    end
    tests++; if (acks !== 55 || alive_count !== 6'd0) begin
      fails++; $display("FAIL kill_all: got acks %0d alive %0d want 55/0", acks, alive_count);
    end
    cyc(); cyc();
    tests++; if (wave_clear !== 1'b1 || landed !== 1'b0) begin
      fails++; $display("FAIL wave_clear: got clear %b landed %b want 1/0", wave_clear, landed);
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick_once();
      if (step_pulse) pulses++;
    end
    tests++; if (pulses !== 0 || origin_x !== 10'd64) begin
      fails++; $display("FAIL clear_frozen: got steps %0d x %0d want 0/64", pulses, origin_x);
    end
    do_restart();
    tests++; if (wave_clear !== 1'b0 || alive_count !== 6'd55 || origin_x !== 10'd64 || origin_y !== 10'd48) begin
      fails++; $display("FAIL restart_c: got clear %b alive %0d (%0d,%0d) want 0 55 (64,48)",
                        wave_clear, alive_count, origin_x, origin_y);
    end
    DrawX = 10'd64; DrawY = 10'd48;
    cyc();
    tests++; if (is_alien !== 1'b1) begin fails++; $display("FAIL restart_mask: got is_alien %b want 1", is_alien); end
    restart = 1'b1; hit_valid = 1'b1; hit_row = 3'd0; hit_col = 4'd0;
    cyc();
    restart = 1'b0; hit_valid = 1'b0;
    tests++; if (hit_ack !== 1'b0 || alive_count !== 6'd55) begin
      fails++; $display("FAIL restart_wins: got ack %b alive %0d want 0/55", hit_ack, alive_count);
    end
    cyc();
    tests++; if (is_alien !== 1'b1 || wave_clear !== 1'b0) begin
      fails++; $display("FAIL restart_hold: got is_alien %b clear %b want 1/0", is_alien, wave_clear);
    end
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_first_step();
    test_march_right();
    test_async_reset();
    test_dead_hit();
    test_same_cycle();
    test_kill_column();
    test_wave_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
